// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master / one-slave Wishbone B4 arbiter.
//   M0 (data port) and M1 (instruction fetch) share a single RAM slave.
//   Round-robin grant, held for the whole CYC period so bursts stay atomic.
//   A watchdog returns ERR to the granted master if its strobe is left
//   unterminated by the slave for TIMEOUT cycles.
// Ports:
//   WB_CLK_I, WB_RST_I (sync, active-low)
//   WBMx_*  : master-side Wishbone ports (ADR/DAT/WE/CTI/STB/CYC in,
//             DAT/ACK/ERR/RTY/STALL out), x = 0, 1
//   WBS_*   : slave-side Wishbone port
//   GNT_O   : one-hot current grant (01 = M0, 10 = M1, 00 = idle)
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  WB_CLK_I,
  input  logic                  WB_RST_I,
  input  logic [ADDR_WIDTH-1:0] WBM0_ADR_I,
  input  logic [DATA_WIDTH-1:0] WBM0_DAT_I,
  output logic [DATA_WIDTH-1:0] WBM0_DAT_O,
  input  logic                  WBM0_WE_I,
  input  logic [2:0]            WBM0_CTI_I,
  input  logic                  WBM0_STB_I,
  input  logic                  WBM0_CYC_I,
  output logic                  WBM0_ACK_O,
  output logic                  WBM0_ERR_O,
  output logic                  WBM0_RTY_O,
  output logic                  WBM0_STALL_O,
  input  logic [ADDR_WIDTH-1:0] WBM1_ADR_I,
  input  logic [DATA_WIDTH-1:0] WBM1_DAT_I,
  output logic [DATA_WIDTH-1:0] WBM1_DAT_O,
  input  logic                  WBM1_WE_I,
  input  logic [2:0]            WBM1_CTI_I,
  input  logic                  WBM1_STB_I,
  input  logic                  WBM1_CYC_I,
  output logic                  WBM1_ACK_O,
  output logic                  WBM1_ERR_O,
  output logic                  WBM1_RTY_O,
  output logic                  WBM1_STALL_O,
  output logic [ADDR_WIDTH-1:0] WBS_ADR_O,
  output logic [DATA_WIDTH-1:0] WBS_DAT_O,
  output logic                  WBS_WE_O,
  output logic [2:0]            WBS_CTI_O,
  output logic                  WBS_STB_O,
  output logic                  WBS_CYC_O,
  input  logic [DATA_WIDTH-1:0] WBS_DAT_I,
  input  logic                  WBS_ACK_I,
  input  logic                  WBS_ERR_I,
  input  logic                  WBS_RTY_I,
  input  logic                  WBS_STALL_I,
  output logic [1:0]            GNT_O
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last;      // 0 = M0 granted last, 1 = M1 granted last
  logic [15:0] wd_cnt;
  logic        wd_err;
  logic        handover;  // first cycle after a direct GNTx -> GNTy switch
  logic        stb_eff;   // strobe of the granted master as seen by the slave
  logic        slv_term;

  assign slv_term = WBS_ACK_I | WBS_ERR_I | WBS_RTY_I;

  always_ff @(posedge WB_CLK_I) begin
    if (!WB_RST_I) begin
      state    <= IDLE;
      last     <= 1'b1;
      wd_cnt   <= '0;
      wd_err   <= 1'b0;
      handover <= 1'b0;
    end else begin
      state    <= state_nxt;
      handover <= (state != IDLE) && (state_nxt != IDLE) && (state_nxt != state);
      if (state == GNT0 && state_nxt != GNT0) last <= 1'b0;
      if (state == GNT1 && state_nxt != GNT1) last <= 1'b1;
      // Watchdog only runs while the grant is stable and the strobe is open.
      if (state == IDLE || state_nxt != state || !stb_eff || slv_term) begin
        wd_cnt <= '0;
        wd_err <= 1'b0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt <= '0;
        wd_err <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
        wd_err <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    stb_eff      = 1'b0;
    WBS_ADR_O    = '0;
    WBS_DAT_O    = '0;
    WBS_WE_O     = 1'b0;
    WBS_CTI_O    = 3'b000;
    WBS_STB_O    = 1'b0;
    WBS_CYC_O    = 1'b0;
    WBM0_DAT_O   = '0;
    WBM0_ACK_O   = 1'b0;
    WBM0_ERR_O   = 1'b0;
    WBM0_RTY_O   = 1'b0;
    WBM0_STALL_O = 1'b1;
    WBM1_DAT_O   = '0;
    WBM1_ACK_O   = 1'b0;
    WBM1_ERR_O   = 1'b0;
    WBM1_RTY_O   = 1'b0;
    WBM1_STALL_O = 1'b1;
    GNT_O        = 2'b00;

    case (state)
      IDLE: begin
        if (WBM0_CYC_I && (!WBM1_CYC_I || last))
          state_nxt = GNT0;
        else if (WBM1_CYC_I && (!WBM0_CYC_I || !last))
          state_nxt = GNT1;
      end
      GNT0: begin
        if (!WBM0_CYC_I) state_nxt = WBM1_CYC_I ? GNT1 : IDLE;
        // During a hand-over cycle any slave termination still belongs to the
        // previous master, so the new master's strobe is held off the slave
        // and terminations are not forwarded to it.
        stb_eff      = WBM0_STB_I & ~handover;
        WBS_ADR_O    = WBM0_ADR_I;
        WBS_DAT_O    = WBM0_DAT_I;
        WBS_WE_O     = WBM0_WE_I;
        WBS_CTI_O    = WBM0_CTI_I;
        WBS_STB_O    = stb_eff;
        WBS_CYC_O    = WBM0_CYC_I;
        WBM0_DAT_O   = WBS_DAT_I;
        WBM0_ACK_O   = WBS_ACK_I & ~handover;
        WBM0_ERR_O   = (WBS_ERR_I & ~handover) | wd_err;
        WBM0_RTY_O   = WBS_RTY_I & ~handover;
        WBM0_STALL_O = WBS_STALL_I | handover;
        GNT_O        = 2'b01;
      end
      GNT1: begin
        if (!WBM1_CYC_I) state_nxt = WBM0_CYC_I ? GNT0 : IDLE;
        stb_eff      = WBM1_STB_I & ~handover;
        WBS_ADR_O    = WBM1_ADR_I;
        WBS_DAT_O    = WBM1_DAT_I;
        WBS_WE_O     = WBM1_WE_I;
        WBS_CTI_O    = WBM1_CTI_I;
        WBS_STB_O    = stb_eff;
        WBS_CYC_O    = WBM1_CYC_I;
        WBM1_DAT_O   = WBS_DAT_I;
        WBM1_ACK_O   = WBS_ACK_I & ~handover;
        WBM1_ERR_O   = (WBS_ERR_I & ~handover) | wd_err;
        WBM1_RTY_O   = WBS_RTY_I & ~handover;
        WBM1_STALL_O = WBS_STALL_I | handover;
        GNT_O        = 2'b10;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
